// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit.
// The immediate generator, ALU decoder and datapath muxes use the same
// encodings, so every select value is defined once here.
package rv32_ctrl_pkg;

  // Controller states; TRAP is terminal until reset.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_WB_MEM,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_e;

  // RV32I base opcodes (IR[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction class as seen by the sequencer.
  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } instr_class_e;

  // Immediate-format select for the immediate generator.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_RS1   = 2'd2,
    SRCA_ZERO  = 2'd3
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'd0,
    ALUOP_BRANCH = 2'd1,
    ALUOP_FUNCT  = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'd0,
    RES_MDR    = 2'd1,
    RES_ALU    = 2'd2
  } result_src_e;

  typedef enum logic {
    PCSRC_ALU    = 1'b0,
    PCSRC_ALUOUT = 1'b1
  } pc_src_e;

  typedef enum logic {
    ADDR_PC     = 1'b0,
    ADDR_ALUOUT = 1'b1
  } addr_src_e;

  // Complete set of control outputs for one cycle.
  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    addr_src_e   addr_src;
    logic        ir_write;
    logic        pc_write;
    pc_src_e     pc_src;
    logic        reg_write;
    result_src_e result_src;
    alu_src_a_e  alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    imm_sel_e    imm_sel;
    logic        retire;
    logic        illegal;
  } ctrl_t;

  // Address calculation uses the S-format offset for stores, I-format otherwise.
  function automatic imm_sel_e imm_for_mem(instr_class_e cls);
    return (cls == CLS_STORE) ? IMM_S : IMM_I;
  endfunction

endpackage

// File: rtl/rv32_opcode_class.sv
// Combinational opcode -> instruction class map.
module rv32_opcode_class
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output instr_class_e class_o
);

  // Anything outside the supported base set is classed illegal.
  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    class_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_LOAD:   class_o = CLS_LOAD;
      OP_STORE:  class_o = CLS_STORE;
      OP_RTYPE:  class_o = CLS_RTYPE;
      OP_ITYPE:  class_o = CLS_ITYPE;
      OP_BRANCH: class_o = CLS_BRANCH;
      OP_JAL:    class_o = CLS_JAL;
      OP_JALR:   class_o = CLS_JALR;
      OP_LUI:    class_o = CLS_LUI;
      OP_AUIPC:  class_o = CLS_AUIPC;
      default:   class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rv32_mc_control.sv
// Multi-cycle RV32I control unit: state register, next-state logic and
// output decode for the shared PC/IR/ALU/memory datapath.
module rv32_mc_control
  import rv32_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       retire,
  output logic       illegal
);

  state_e       state_q, state_d;
  instr_class_e cls;
  ctrl_t        ctrl;

  rv32_opcode_class u_opcode_class (
    .opcode_i (opcode),
    .class_o  (cls)
  );

  // State register; synchronous reset returns the sequencer to FETCH.
  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; memory states hold until the request completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_LOAD,
          CLS_STORE:  state_d = S_MEM_ADDR;
          CLS_RTYPE:  state_d = S_EXEC_R;
          CLS_ITYPE:  state_d = S_EXEC_I;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JAL:    state_d = S_JAL;
          CLS_JALR:   state_d = S_JALR;
          CLS_LUI:    state_d = S_LUI;
          CLS_AUIPC:  state_d = S_AUIPC;
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (cls == CLS_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:    state_d = S_WB_ALU;
      S_WB_ALU:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL,
      S_JALR:      state_d = S_LINK;
      S_LINK,
      S_LUI,
      S_AUIPC:     state_d = S_WB_ALU;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode from the current state; reset forces every strobe low so an
  // abandoned request, write or retire never leaks out during rst.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_src = ADDR_PC;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_a = SRCA_PC;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_src    = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_sel   = (cls == CLS_JAL) ? IMM_J : IMM_B;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_sel   = imm_for_mem(cls);
      end
      S_MEM_READ: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_src = ADDR_ALUOUT;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MDR;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.addr_src = ADDR_ALUOUT;
        ctrl.retire   = mem_ready;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_sel   = IMM_I;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_BRANCH;
        ctrl.retire    = 1'b1;
        ctrl.pc_write  = branch_taken;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      S_JAL: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_ALUOUT;
      end
      S_JALR: begin
        // Target taken straight from the ALU; datapath clears bit 0.
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_sel   = IMM_I;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_LINK: begin
        // Link value OLDPC + 4 lands in ALUOut for WB_ALU.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_AUIPC: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_TRAP:  ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
    if (rst) ctrl = '0;
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign addr_src   = ctrl.addr_src;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign reg_write  = ctrl.reg_write;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign imm_sel    = ctrl.imm_sel;
  assign retire     = ctrl.retire;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_rv32_mc_control.sv
// Bench for rv32_mc_control: builds the expected per-cycle output trace of each
// instruction from its class, wait states and branch outcome, then replays it.
module tb_rv32_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_sel;
  logic       retire, illegal;

  rv32_mc_control dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_src     (addr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .retire       (retire),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_sel;
    logic       retire, illegal;
  } outs_t;

  typedef struct {
    string      tag;
    bit         rst;
    bit         rdy;
    bit         bt;
    logic [6:0] op;
    outs_t      o;
  } cyc_t;

  outs_t act;
  assign act = {mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, imm_sel, retire, illegal};

  cyc_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         BAD = 7'b1111111;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %05h expected %05h", tag, cycle, got, exp);
    end
  endtask

  // Queue one expected cycle; rdy/bt are the inputs driven in that cycle.
  task automatic push(input string tag, input bit rdy, input bit bt, input logic [6:0] op,
                      input outs_t o, input bit r = 1'b0);
    cyc_t c;
    c.tag = tag; c.rst = r; c.rdy = rdy; c.bt = bt; c.op = op; c.o = o;
    exp_q.push_back(c);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push_reset(input string tag, input int n);
    outs_t o = '0;
    for (int i = 0; i < n; i++) push(tag, rb(), rb(), 7'($urandom), o, 1'b1);
  endtask

  // Fetch with fw wait cycles, then decode; opcode is don't-care during fetch.
  task automatic gen_front(input logic [6:0] op, input int fw);
    outs_t o;
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_req = 1;
      push("fetch_wait", 1'b0, rb(), 7'($urandom), o);
    end
    o = '0; o.mem_req = 1; o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 2;
    push("fetch_done", 1'b1, rb(), 7'($urandom), o);
    o = '0; o.alu_src_a = 1; o.alu_src_b = 1;
    o.imm_sel = (op == JAL) ? 3'd4 : 3'd2;
    push("decode", rb(), rb(), op, o);
  endtask

  task automatic gen_wb_alu(input logic [6:0] op);
    outs_t o = '0;
    o.reg_write = 1; o.retire = 1;
    push("wb_alu", rb(), rb(), op, o);
  endtask

  task automatic gen_link(input logic [6:0] op);
    outs_t o = '0;
    o.alu_src_a = 1; o.alu_src_b = 2;
    push("link", rb(), rb(), op, o);
    gen_wb_alu(op);
  endtask

  // Whole legal instruction: fw fetch waits, mw data-memory waits, bt branch outcome.
  task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input bit bt);
    outs_t o;
    gen_front(op, fw);
    o = '0;
    case (op)
      LOAD, STORE: begin
        o.alu_src_a = 2; o.alu_src_b = 1; o.imm_sel = (op == STORE) ? 3'd1 : 3'd0;
        push("mem_addr", rb(), rb(), op, o);
        o = '0; o.mem_req = 1; o.addr_src = 1; o.mem_we = (op == STORE);
        for (int i = 0; i < mw; i++) push("mem_wait", 1'b0, rb(), op, o);
        o.retire = (op == STORE);
        push("mem_done", 1'b1, rb(), op, o);
        if (op == LOAD) begin
          o = '0; o.reg_write = 1; o.result_src = 1; o.retire = 1;
          push("wb_mem", rb(), rb(), op, o);
        end
      end
      RTYPE: begin
        o.alu_src_a = 2; o.alu_op = 2;
        push("exec_r", rb(), rb(), op, o);
        gen_wb_alu(op);
      end
      ITYPE: begin
        o.alu_src_a = 2; o.alu_src_b = 1; o.alu_op = 2;
        push("exec_i", rb(), rb(), op, o);
        gen_wb_alu(op);
      end
      BRANCH: begin
        o.alu_src_a = 2; o.alu_op = 1; o.retire = 1; o.pc_write = bt; o.pc_src = 1;
        push(bt ? "branch_taken" : "branch_not", rb(), bt, op, o);
      end
      JAL: begin
        o.pc_write = 1; o.pc_src = 1;
        push("jal", rb(), rb(), op, o);
        gen_link(op);
      end
      JALR: begin
        o.alu_src_a = 2; o.alu_src_b = 1; o.pc_write = 1;
        push("jalr", rb(), rb(), op, o);
        gen_link(op);
      end
      LUI: begin
        o.alu_src_a = 3; o.alu_src_b = 1; o.imm_sel = 3;
        push("lui", rb(), rb(), op, o);
        gen_wb_alu(op);
      end
      AUIPC: begin
        o.alu_src_a = 1; o.alu_src_b = 1; o.imm_sel = 3;
        push("auipc", rb(), rb(), op, o);
        gen_wb_alu(op);
      end
      default: ;
    endcase
  endtask

  // Replay the queue: drive at negedge, compare 1 time unit later.
  task automatic run_queue();
    cyc_t c;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      @(negedge clk);
      rst = c.rst; mem_ready = c.rdy; branch_taken = c.bt; opcode = c.op;
      #1;
      check(c.tag, act, c.o);
      cycle++;
    end
  endtask

  logic [6:0] legal_ops [9] = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, LUI, AUIPC};

  initial begin
    outs_t o;
    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;

    push_reset("reset", 3);
    gen_instr(RTYPE, 0, 0, 0);
    gen_instr(LOAD, 3, 3, 0);
    gen_instr(BRANCH, 0, 0, 1);
    gen_instr(BRANCH, 0, 0, 0);
    gen_instr(JAL, 0, 0, 0);
    gen_instr(JALR, 0, 0, 0);
    gen_instr(STORE, 0, 0, 0);
    gen_instr(ITYPE, 1, 0, 0);
    gen_instr(LUI, 0, 0, 0);
    gen_instr(AUIPC, 0, 0, 0);
    run_queue();

    for (int n = 0; n < 60; n++)
      gen_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3),
                $urandom_range(0, 3), rb());
    run_queue();

    // Reset while a store waits: request dropped, nothing retires, fetch resumes.
    gen_front(STORE, 1);
    o = '0; o.alu_src_a = 2; o.alu_src_b = 1; o.imm_sel = 1;
    push("mem_addr", rb(), rb(), STORE, o);
    o = '0; o.mem_req = 1; o.mem_we = 1; o.addr_src = 1;
    push("store_wait", 1'b0, rb(), STORE, o);
    push("store_wait", 1'b0, rb(), STORE, o);
    push("store_abort", 1'b1, rb(), STORE, '0, 1'b1);
    gen_instr(RTYPE, 0, 0, 0);
    run_queue();

    // Illegal opcode: sticky illegal, no strobes, cleared only by reset.
    gen_front(BAD, 0);
    o = '0; o.illegal = 1;
    for (int i = 0; i < 20; i++) push("trap_hold", rb(), rb(), BAD, o);
    push_reset("trap_reset", 1);
    gen_instr(LOAD, 0, 0, 0);
    run_queue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
